bin_counter: RTL and testbench
==============================

Name: bin_counter

Overview:
- Synchronous, parameterizable binary up/down counter with a registered output.
- A single mode input selects the count direction every clock cycle: 0 counts up, 1 counts down.
- Free-running: the counter advances on every clock edge unless reset is active. There is no enable or load.
- Intended as a simple timebase/sequence-generator leaf block.

Parameters:
- WIDTH, 8, counter and output width in bits (must be >= 1).

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous, active-high. Forces o_cnt to 0 on the next rising edge.
- i_mode  input  1  direction select, sampled at each rising edge: 0 = increment, 1 = decrement.
- o_cnt  output  WIDTH  current counter value, driven directly from the state register.

Behaviour:
- Single one-clock design: one clock (i_clk); reset is synchronous and active-high (i_rst). No asynchronous reset path.
- State: one WIDTH-bit register cnt_q; o_cnt = cnt_q, with no combinational path from inputs to output.
- Reset value: o_cnt = 0. Applied on any rising edge where i_rst = 1. Reset has priority over i_mode.
- Before the first reset edge, o_cnt is undefined; the system must assert i_rst for at least one clock edge after power-up.
- Counting at each rising edge with i_rst = 0:
  - i_mode = 0: cnt_q <= cnt_q + 1, modulo 2^WIDTH.
  - i_mode = 1: cnt_q <= cnt_q - 1, modulo 2^WIDTH.
- Latency: one clock. A change on i_mode or i_rst takes effect on the first rising edge at which the new level is sampled.
- No internal pipelining or look-ahead.
- Wrap-around:
  - Up: 2^WIDTH-1 -> 0 (e.g. 255 -> 0 for WIDTH = 8).
  - Down: 0 -> 2^WIDTH-1 (e.g. 0 -> 255).
  - No saturation, no flags, no sticky state.
- Direction change mid-count: no bubble or skip. The next edge after i_mode changes steps ±1 from the current value.
- Reset mid-operation:
  - Clears to 0 regardless of direction or value.
  - The first edge after i_rst deasserts steps from 0 per the current i_mode (down mode gives 2^WIDTH-1).
- Holding i_rst high for N edges keeps o_cnt = 0 for all N edges.
- Arithmetic: WIDTH-bit unsigned. Carry/borrow discarded.

Test Plan:
- Reset and up-count (WIDTH = 8, 10 ns clock):
  - i_rst = 1 for the first edge, then 0, with i_mode = 0.
  - Required: o_cnt = 0 after the reset edge, then 1, 2, 3, ...
  - After 25 counting edges, o_cnt = 25.
- Direction switch:
  - From o_cnt = 25 set i_mode = 1.
  - Required: the next edges give 24, 23, ..., 0, then 255, 254, ...
  - After 30 down edges, o_cnt = 251.
- Reset during down-count:
  - With i_mode = 1 and o_cnt = 251, pulse i_rst high for one edge.
  - Required: o_cnt = 0 on that edge; the following edges give 255, 254, ...
  - After 10 edges, o_cnt = 246.
- Up wrap:
  - Reset, i_mode = 0, run 256 edges.
  - Required: o_cnt passes 254, 255, then 0.
  - No glitch; the value after 256 edges is 0.
- Reset priority and hold:
  - Hold i_rst = 1 for 5 edges while toggling i_mode.
  - Required: o_cnt = 0 on every one of those edges.
- Single-cycle mode toggles:
  - From o_cnt = 10, apply i_mode sequence 0, 1, 0, 1 on consecutive edges.
  - Required: o_cnt = 11, 10, 11, 10.

Source files
------------

// File: rtl/bin_counter.sv
// Free-running WIDTH-bit binary up/down counter with a registered output.
// i_mode picks the direction each edge (0 = up, 1 = down); i_rst clears synchronously.
module bin_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_cnt
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Carry/borrow fall off the top, giving modulo-2^WIDTH wrap in both directions.
  always_comb begin
    cnt_d = cnt_q + One;
    if (i_mode) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: tb/tb_bin_counter.sv
// Self-checking bench for bin_counter: a reference model pushes the expected value of
// every edge into a scoreboard queue, which each scenario pops and compares against o_cnt.
module tb_bin_counter;

  localparam int unsigned Width = 8;

  logic             clk;
  logic             rst;
  logic             mode;
  logic [Width-1:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [Width-1:0] model_cnt = '0;
  logic [Width-1:0] sb_q[$];
  logic [Width-1:0] exp_v;

  bin_counter #(
    .WIDTH(Width)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_mode(mode),
    .o_cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one edge worth of inputs, pushes the model's prediction, and returns
  // 1 ns after the rising edge so the caller can pop and compare.
  task automatic drive(input logic r, input logic m);
    @(negedge clk);
    rst  = r;
    mode = m;
    if (r) begin
      model_cnt = '0;
    end else if (m) begin
      model_cnt = model_cnt - 8'd1;
    end else begin
      model_cnt = model_cnt + 8'd1;
    end
    sb_q.push_back(model_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (cnt !== exp_v) begin
      errors++;
      $display("FAIL reset: o_cnt=%0d expected=%0d", cnt, exp_v);
    end
  endtask

  task automatic test_up_count();
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (cnt !== exp_v) begin
        errors++;
        $display("FAIL up_count[%0d]: o_cnt=%0d expected=%0d", i, cnt, exp_v);
      end
    end
    checks++;
    if (cnt !== 8'd25) begin
      errors++;
      $display("FAIL up_count_final: o_cnt=%0d expected=25", cnt);
    end
  endtask

  task automatic test_direction_switch();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1);
      exp_v = sb_q.pop_front();
      checks++;
      if (cnt !== exp_v) begin
        errors++;
        $display("FAIL dir_switch[%0d]: o_cnt=%0d expected=%0d", i, cnt, exp_v);
      end
    end
    checks++;
    if (cnt !== 8'd251) begin
      errors++;
      $display("FAIL dir_switch_final: o_cnt=%0d expected=251", cnt);
    end
  endtask

  task automatic test_reset_during_down();
    drive(1'b1, 1'b1);
    exp_v = sb_q.pop_front();
    checks++;
    if (cnt !== exp_v) begin
      errors++;
      $display("FAIL down_reset: o_cnt=%0d expected=%0d", cnt, exp_v);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1);
      exp_v = sb_q.pop_front();
      checks++;
      if (cnt !== exp_v) begin
        errors++;
        $display("FAIL down_after_reset[%0d]: o_cnt=%0d expected=%0d", i, cnt, exp_v);
      end
    end
    checks++;
    if (cnt !== 8'd246) begin
      errors++;
      $display("FAIL down_after_reset_final: o_cnt=%0d expected=246", cnt);
    end
  endtask

  task automatic test_up_wrap();
    drive(1'b1, 1'b0);
    exp_v = sb_q.pop_front();
    checks++;
    if (cnt !== exp_v) begin
      errors++;
      $display("FAIL wrap_reset: o_cnt=%0d expected=%0d", cnt, exp_v);
    end
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if (cnt !== exp_v) begin
        errors++;
        $display("FAIL up_wrap[%0d]: o_cnt=%0d expected=%0d", i, cnt, exp_v);
      end
      if (i == 254) begin
        checks++;
        if (cnt !== 8'd255) begin
          errors++;
          $display("FAIL up_wrap_top: o_cnt=%0d expected=255", cnt);
        end
      end
    end
    checks++;
    if (cnt !== 8'd0) begin
      errors++;
      $display("FAIL up_wrap_final: o_cnt=%0d expected=0", cnt);
    end
  endtask

  task automatic test_reset_hold();
    // Run up a non-zero value first so a missed reset would be visible.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0);
      void'(sb_q.pop_front());
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'(i % 2));
      exp_v = sb_q.pop_front();
      checks++;
      if (cnt !== exp_v) begin
        errors++;
        $display("FAIL reset_hold[%0d]: o_cnt=%0d expected=%0d", i, cnt, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [Width-1:0] want[4];
    logic             seq[4];
    want = '{8'd11, 8'd10, 8'd11, 8'd10};
    seq  = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0);
      void'(sb_q.pop_front());
    end
    checks++;
    if (cnt !== 8'd10) begin
      errors++;
      $display("FAIL toggle_start: o_cnt=%0d expected=10", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, seq[i]);
      exp_v = sb_q.pop_front();
      checks++;
      if (cnt !== exp_v || cnt !== want[i]) begin
        errors++;
        $display("FAIL toggle[%0d]: o_cnt=%0d expected=%0d", i, cnt, want[i]);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    test_reset();
    test_up_count();
    test_direction_switch();
    test_reset_during_down();
    test_up_wrap();
    test_reset_hold();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: entries=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
